// File: rtl/posit_mac_pkg.sv
// posit_mac_pkg: shared widths, source IDs and the shift-request record for the posit MAC
package posit_mac_pkg;
  function automatic int data_width(input int n);
    return 10 * n - 24;
  endfunction
  localparam int DEF_N = 8;
  localparam int DEF_DATA_WIDTH = data_width(DEF_N);
  localparam int DEF_SHIFT_BITS = 6;
  localparam int DEF_MAX_SHIFT = 48;
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] x;
    logic [DEF_SHIFT_BITS-1:0] s;
    logic                      pad;
    logic                      src;
  } shift_req_t;
endpackage

// File: rtl/posit_rshift_sticky.sv
// posit_rshift_sticky: combinational log-stage right shifter with pad fill and sticky collection
//   x_i/s_i/pad_i : operand, shift amount, fill bit
//   r_o/sticky_o  : shifted word, OR of every bit dropped off the low end
module posit_rshift_sticky #(
  parameter int DW = 56,
  parameter int SB = 6
) (
  input  logic [DW-1:0] x_i,
  input  logic [SB-1:0] s_i,
  input  logic          pad_i,
  output logic [DW-1:0] r_o,
  output logic          sticky_o
);
  // Stage k shifts by 2**k; the bits it drops are the low 2**k of that stage's input.
  always_comb begin
    r_o = x_i;
    sticky_o = 1'b0;
    for (int k = 0; k < SB; k++) begin
      if (s_i[k]) begin
        sticky_o = sticky_o | (|(r_o & ~({DW{1'b1}} << (1 << k))));
        r_o = (r_o >> (1 << k)) | (pad_i ? ~({DW{1'b1}} >> (1 << k)) : '0);
      end
    end
  end
endmodule

// File: rtl/posit_shift_arbiter.sv
// posit_shift_arbiter: round-robin share of one alignment shifter between two requesters
//   a_*/b_*   : valid/ready request ports (operand, shift amount, fill bit)
//   rsp_*     : valid/ready response (shifted word, sticky, source ID)
//   busy      : any pipeline stage occupied
module posit_shift_arbiter
  import posit_mac_pkg::*;
#(
  parameter int N = 8,
  parameter int DATA_WIDTH = data_width(N),
  parameter int SHIFT_BITS = 6,
  parameter int MAX_SHIFT = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [DATA_WIDTH-1:0] a_x,
  input  logic [SHIFT_BITS-1:0] a_s,
  input  logic                  a_pad,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [DATA_WIDTH-1:0] b_x,
  input  logic [SHIFT_BITS-1:0] b_s,
  input  logic                  b_pad,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_r,
  output logic                  rsp_sticky,
  output logic                  rsp_src,
  output logic                  busy
);
  localparam logic [SHIFT_BITS-1:0] S_MAX = SHIFT_BITS'(MAX_SHIFT);
  logic                  prio_q, prio_d;
  logic                  s1_valid_q, s1_valid_d, rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] s1_x_q, rsp_r_q, sh_r;
  logic [SHIFT_BITS-1:0] s1_s_q, s_req;
  logic                  s1_pad_q, s1_src_q, rsp_sticky_q, rsp_src_q, sh_sticky;
  logic                  s2_ready, s1_ready, grant_a, grant_b, acc;
  assign s2_ready = !rsp_valid_q || rsp_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  // prio holds the source ID that wins a tie
  assign grant_b = b_valid && (!a_valid || prio_q == SRC_B);
  assign grant_a = a_valid && !grant_b;
  assign acc = s1_ready && (grant_a || grant_b);
  assign a_ready = s1_ready && grant_a;
  assign b_ready = s1_ready && grant_b;
  always_comb begin
    s_req = grant_b ? b_s : a_s;
    s1_valid_d = acc || (s1_valid_q && !s2_ready);
    rsp_valid_d = s2_ready ? s1_valid_q : rsp_valid_q;
    prio_d = acc ? (grant_a ? SRC_B : SRC_A) : prio_q;
  end
  posit_rshift_sticky #(.DW(DATA_WIDTH), .SB(SHIFT_BITS)) u_shift (
    .x_i(s1_x_q), .s_i(s1_s_q), .pad_i(s1_pad_q), .r_o(sh_r), .sticky_o(sh_sticky)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= SRC_A;
      s1_valid_q <= 1'b0;
      s1_x_q <= '0;
      s1_s_q <= '0;
      s1_pad_q <= 1'b0;
      s1_src_q <= SRC_A;
      rsp_valid_q <= 1'b0;
      rsp_r_q <= '0;
      rsp_sticky_q <= 1'b0;
      rsp_src_q <= SRC_A;
    end else begin
      prio_q <= prio_d;
      s1_valid_q <= s1_valid_d;
      rsp_valid_q <= rsp_valid_d;
      if (acc) begin
        s1_x_q <= grant_b ? b_x : a_x;
        s1_s_q <= (s_req > S_MAX) ? S_MAX : s_req;
        s1_pad_q <= grant_b ? b_pad : a_pad;
        s1_src_q <= grant_b ? SRC_B : SRC_A;
      end
      if (s1_valid_q && s2_ready) begin
        rsp_r_q <= sh_r;
        rsp_sticky_q <= sh_sticky;
        rsp_src_q <= s1_src_q;
      end
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_r = rsp_r_q;
  assign rsp_sticky = rsp_sticky_q;
  assign rsp_src = rsp_src_q;
  assign busy = s1_valid_q || rsp_valid_q;
endmodule

// File: tb/tb_posit_shift_arbiter.sv
// tb_posit_shift_arbiter: directed self-checking bench for the shared alignment shifter
module tb_posit_shift_arbiter;
  import posit_mac_pkg::*;
  localparam int DW = DEF_DATA_WIDTH;
  logic clk = 1'b0, rst = 1'b1;
  logic a_valid = 0, b_valid = 0, a_pad = 0, b_pad = 0, rsp_ready = 0;
  logic [DW-1:0] a_x = '0, b_x = '0;
  logic [5:0] a_s = '0, b_s = '0;
  logic a_ready, b_ready, rsp_valid, rsp_sticky, rsp_src, busy;
  logic [DW-1:0] rsp_r;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  posit_shift_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_x(a_x), .a_s(a_s), .a_pad(a_pad),
    .b_valid(b_valid), .b_ready(b_ready), .b_x(b_x), .b_s(b_s), .b_pad(b_pad),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_r(rsp_r),
    .rsp_sticky(rsp_sticky), .rsp_src(rsp_src), .busy(busy)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    a_valid = 0; b_valid = 0; rst = 1;
    step();
    rst = 0;
  endtask
  task automatic test_reset;
    rst = 1; a_valid = 0; b_valid = 0;
    step(); step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rsp_r !== '0) begin errors++; $display("FAIL reset_r: got %h expected 0", rsp_r); end
    checks++; if ({rsp_sticky, rsp_src} !== 2'b00) begin errors++; $display("FAIL reset_st_src: got %b expected 00", {rsp_sticky, rsp_src}); end
    rst = 0;
  endtask
  task automatic test_basic_a;
    rsp_ready = 1; a_x = 56'hFF; a_s = 4; a_pad = 0; a_valid = 1;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL basic_ready: got %b expected 10", {a_ready, b_ready}); end
    step(); a_valid = 0; #1;
    checks++; if ({rsp_valid, busy} !== 2'b01) begin errors++; $display("FAIL basic_t1: got %b expected 01", {rsp_valid, busy}); end
    step();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", rsp_valid); end
    checks++; if (rsp_r !== 56'h0F) begin errors++; $display("FAIL basic_r: got %h expected %h", rsp_r, 56'h0F); end
    checks++; if ({rsp_sticky, rsp_src} !== 2'b10) begin errors++; $display("FAIL basic_st_src: got %b expected 10", {rsp_sticky, rsp_src}); end
    step();
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL basic_drain: got %b expected 00", {rsp_valid, busy}); end
  endtask
  task automatic test_clamp_pad;
    rsp_ready = 1; b_x = 56'h80_0000_0000_0000; b_s = 60; b_pad = 1; b_valid = 1;
    step(); b_valid = 0; step();
    checks++; if (rsp_r !== 56'hFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL clamp_r: got %h expected %h", rsp_r, 56'hFF_FFFF_FFFF_FF80); end
    checks++; if ({rsp_valid, rsp_sticky, rsp_src} !== 3'b101) begin errors++; $display("FAIL clamp_flags: got %b expected 101", {rsp_valid, rsp_sticky, rsp_src}); end
    step();
    b_x = 56'h01_0000_0000_0001; b_s = 48; b_pad = 0; b_valid = 1;
    step(); b_valid = 0; step();
    checks++; if (rsp_r !== 56'h1) begin errors++; $display("FAIL max48_r: got %h expected %h", rsp_r, 56'h1); end
    checks++; if ({rsp_valid, rsp_sticky, rsp_src} !== 3'b111) begin errors++; $display("FAIL max48_flags: got %b expected 111", {rsp_valid, rsp_sticky, rsp_src}); end
    step();
  endtask
  task automatic test_zero_shift;
    rsp_ready = 1; a_x = 56'h12_3456_789A_BCDE; a_s = 0; a_pad = 1; a_valid = 1;
    step(); a_valid = 0; step();
    checks++; if (rsp_r !== 56'h12_3456_789A_BCDE) begin errors++; $display("FAIL zero_r: got %h expected %h", rsp_r, 56'h12_3456_789A_BCDE); end
    checks++; if ({rsp_valid, rsp_sticky, rsp_src} !== 3'b100) begin errors++; $display("FAIL zero_flags: got %b expected 100", {rsp_valid, rsp_sticky, rsp_src}); end
    step();
  endtask
  task automatic test_round_robin;
    logic [DW-1:0] exp_r;
    do_reset();
    rsp_ready = 1; a_s = 0; b_s = 0; a_pad = 0; b_pad = 0;
    for (int c = 0; c < 8; c++) begin
      a_valid = c < 6; b_valid = c < 6;
      a_x = 56'hA0 + 56'(c); b_x = 56'hB0 + 56'(c);
      #1;
      if (c < 6) begin
        checks++; if ({a_ready, b_ready} !== {c % 2 == 0, c % 2 == 1}) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", c, {a_ready, b_ready}, {c % 2 == 0, c % 2 == 1}); end
      end
      if (c >= 2) begin
        exp_r = (c % 2 == 0 ? 56'hA0 : 56'hB0) + 56'(c - 2);
        checks++; if ({rsp_valid, rsp_src, rsp_r} !== {1'b1, c % 2 == 1, exp_r}) begin errors++; $display("FAIL rr_rsp%0d: got v=%b src=%b r=%h expected v=1 src=%b r=%h", c, rsp_valid, rsp_src, rsp_r, c % 2 == 1, exp_r); end
      end
      step();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle: got %b expected 0", busy); end
  endtask
  task automatic test_backpressure;
    int acc = 0;
    do_reset();
    rsp_ready = 0; a_x = 56'hAA; b_x = 56'hBB; a_s = 0; b_s = 0; a_valid = 1; b_valid = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if ((a_valid && a_ready) || (b_valid && b_ready)) acc++;
      checks++; if ({a_ready, b_ready} !== {c == 0, c == 1}) begin errors++; $display("FAIL bp_ready%0d: got %b expected %b", c, {a_ready, b_ready}, {c == 0, c == 1}); end
      if (c >= 2) begin
        checks++; if ({rsp_valid, rsp_src, rsp_r} !== {1'b1, 1'b0, 56'hAA}) begin errors++; $display("FAIL bp_hold%0d: got v=%b src=%b r=%h expected v=1 src=0 r=aa", c, rsp_valid, rsp_src, rsp_r); end
      end
      step();
    end
    checks++; if (acc !== 2) begin errors++; $display("FAIL bp_accepts: got %0d expected 2", acc); end
    a_valid = 0; b_valid = 0; rsp_ready = 1; #1;
    checks++; if ({rsp_valid, rsp_src, rsp_r} !== {1'b1, 1'b0, 56'hAA}) begin errors++; $display("FAIL bp_drain0: got v=%b src=%b r=%h expected v=1 src=0 r=aa", rsp_valid, rsp_src, rsp_r); end
    step();
    checks++; if ({rsp_valid, rsp_src, rsp_r} !== {1'b1, 1'b1, 56'hBB}) begin errors++; $display("FAIL bp_drain1: got v=%b src=%b r=%h expected v=1 src=1 r=bb", rsp_valid, rsp_src, rsp_r); end
    step();
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL bp_empty: got %b expected 00", {rsp_valid, busy}); end
  endtask
  task automatic test_reset_midflight;
    do_reset();
    rsp_ready = 0; a_s = 0; b_s = 0; a_pad = 0; b_pad = 0;
    b_x = 56'h5; b_valid = 1;
    step(); b_valid = 0; a_x = 56'h6; a_valid = 1; #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL mid_fill: got %b expected 1", a_ready); end
    step(); a_valid = 0; #1;
    checks++; if ({rsp_valid, busy, a_ready} !== 3'b110) begin errors++; $display("FAIL mid_full: got %b expected 110", {rsp_valid, busy, a_ready}); end
    rst = 1; step(); rst = 0;
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL mid_cleared: got %b expected 00", {rsp_valid, busy}); end
    rsp_ready = 1; a_x = 56'h3C; a_s = 2; a_pad = 1; a_valid = 1; b_x = 56'h7; b_valid = 1; #1;
    checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL mid_prio: got %b expected 10", {a_ready, b_ready}); end
    step(); a_valid = 0; b_valid = 0; #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_lat1: got %b expected 0", rsp_valid); end
    step();
    checks++; if (rsp_r !== 56'hC0_0000_0000_000F) begin errors++; $display("FAIL mid_r: got %h expected %h", rsp_r, 56'hC0_0000_0000_000F); end
    checks++; if ({rsp_valid, rsp_sticky, rsp_src} !== 3'b100) begin errors++; $display("FAIL mid_flags: got %b expected 100", {rsp_valid, rsp_sticky, rsp_src}); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle: got %b expected 0", busy); end
  endtask
  initial begin
    test_reset();
    test_basic_a();
    test_clamp_pad();
    test_zero_shift();
    test_round_robin();
    test_backpressure();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/posit_shift_arbiter.md
Name: posit_shift_arbiter

Overview:
Shares one alignment right-shifter datapath between two requesters in the posit MAC: port A (product alignment) and port B (accumulator alignment). Arbitrates round-robin and runs a 2-stage pipeline: request register, then shift/sticky compute into an output register. Returns the shifted word, a sticky bit and the source ID through valid/ready handshakes with full backpressure.

Parameters:
N, 8, posit width; sets datapath width.
DATA_WIDTH, 10*N-24, width of shift operand and result (56 at N=8).
SHIFT_BITS, 6, width of shift-amount fields.
MAX_SHIFT, 48, clamp ceiling for the shift amount.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
a_valid  in  1  requester A has a request.
a_ready  out  1  A request accepted this cycle (a_valid && a_ready).
a_x  in  DATA_WIDTH  A operand.
a_s  in  SHIFT_BITS  A shift amount.
a_pad  in  1  A fill bit.
b_valid, b_ready, b_x, b_s, b_pad  same as A, for requester B.
rsp_valid  out  1  result valid.
rsp_ready  in  1  consumer accepts the result.
rsp_r  out  DATA_WIDTH  shifted result.
rsp_sticky  out  1  OR of all bits shifted out of the low end.
rsp_src  out  1  0 = A, 1 = B.
busy  out  1  either pipeline stage holds a valid entry.

Behaviour:
- Reset: s1_valid=0; rsp_valid=0; rsp_r=0; rsp_sticky=0; rsp_src=0; prio=A; busy=0. Reset mid-operation discards in-flight entries and produces no response.
- Readies: s2_ready = !rsp_valid || rsp_ready; s1_ready = !s1_valid || s2_ready.
- Arbitration is combinational and sticky-free:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the port selected by prio.
  - a_ready = s1_ready && grant_A; b_ready likewise.
- Ready may depend on valid. Requesters must not make valid depend on ready.
- prio changes only on an accepted grant: it becomes the non-granted port. No grant, or a stalled s1, leaves prio unchanged.
- Fairness: with both requesters continuously valid and no backpressure, grants alternate A, B, A, B.
- Stage 1, on accept: register x, pad and src. Register s_eff = min(s, MAX_SHIFT). Set s1_valid=1.
- Stage 1 clears when s2 takes its entry and no new grant occurs. Accept and hand-off in the same cycle keeps s1_valid=1 (full throughput, one request per cycle).
- Stage 2 computes on s1 contents when s1_valid && s2_ready:
  - R[i] = X[i+s_eff] if i+s_eff < DATA_WIDTH, else pad.
  - sticky = OR of X[s_eff-1:0]; sticky=0 when s_eff=0.
  - Load rsp_r, rsp_sticky and rsp_src; set rsp_valid=1.
- Stage 2 pipeline rule:
  - rsp_valid && rsp_ready with no new s1 entry: rsp_valid <= 0.
  - rsp_valid && !rsp_ready: all output fields hold stable, and s1 stalls once full.
- Latency: accept cycle T gives rsp_valid at T+2 when no stall.
- Capacity: at most 2 transactions in flight. Responses are returned in acceptance order.
- pad is a per-request field; a_pad and b_pad may differ.
- busy = s1_valid || rsp_valid.

Decomposition:
- Shared package (posit_mac_pkg):
  - DATA_WIDTH derivation (10*N-24).
  - SRC_A=0, SRC_B=1 constants.
  - Shift-request struct {x, s, pad, src}.
- One natural sub-module: posit_rshift_sticky. It is combinational: {X, S, pad} -> {R, sticky}, built as log-stage barrel shift stages with sticky OR accumulation. It is instantiated in stage 2.
- Arbiter and pipeline control stay in the top module.

Test Plan:
- Basic A (N=8): a_x=56'hFF, a_s=4, a_pad=0, only A valid -> after 2 cycles rsp_r=56'h0F, rsp_sticky=1, rsp_src=0.
- Clamp plus pad (B): b_x=56'h80_0000_0000_0000, b_s=60, b_pad=1 -> rsp_r=56'hFF_FFFF_FFFF_FF80, rsp_sticky=0, rsp_src=1.
- Zero shift: a_x=56'h12_3456_789A_BCDE, a_s=0 -> rsp_r equals input, rsp_sticky=0.
- Round-robin: both valid for 6 cycles with rsp_ready=1 -> rsp_src sequence 0,1,0,1,0,1; one accept per cycle; prio toggles on every grant.
- Backpressure: rsp_ready=0 for 5 cycles with both valid -> exactly 2 accepts, then a_ready=b_ready=0. rsp fields stay stable. After release, responses drain in acceptance order and none are lost or duplicated.
- Reset mid-flight: assert rst for 1 cycle with both stages full -> next cycle rsp_valid=0, busy=0, prio=A. The first request after reset returns correctly with 2-cycle latency.
